// File: rtl/serial_addsub_nb.sv
// Bit-serial two's-complement adder/subtractor: one full-adder slice, LSB first.
// Optional macro SERIAL_ADDSUB_ERR_EN adds a sticky err output for start-while-busy.
module serial_addsub_nb #(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             sub,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] result,
   output logic             c_out,
   output logic             ovf
`ifdef SERIAL_ADDSUB_ERR_EN
   ,
   output logic             err
`endif
);

   localparam int CW = $clog2(WIDTH);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t           r_state;
   state_t           w_state_next;
   logic [WIDTH-1:0] r_a;
   logic [WIDTH-1:0] r_b;
   logic [WIDTH-1:0] r_result;
   logic             r_carry;
   logic [CW-1:0]    r_cnt;
   logic             r_c_out;
   logic             r_ovf;
   logic             w_load;
   logic             w_step;
   logic             w_last;
   logic             w_sum;
   logic             w_cout;

   assign w_sum  = r_a[0] ^ r_b[0] ^ r_carry;
   assign w_cout = (r_a[0] & r_b[0]) | (r_carry & (r_a[0] ^ r_b[0]));
   assign w_last = (r_cnt == CW'(WIDTH - 1));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   always_comb begin
      w_state_next = r_state;
      w_load       = 1'b0;
      w_step       = 1'b0;
      busy         = 1'b0;
      done         = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (start) begin
               w_state_next = S_RUN;
               w_load       = 1'b1;
            end
         end
         S_RUN: begin
            busy   = 1'b1;
            w_step = 1'b1;
            if (w_last) begin
               w_state_next = S_DONE;
            end
         end
         S_DONE: begin
            done = 1'b1;
            if (start) begin
               w_state_next = S_RUN;
               w_load       = 1'b1;
            end else begin
               w_state_next = S_IDLE;
            end
         end
         default: w_state_next = S_IDLE;
      endcase
   end

   // Subtraction is a + ~b + 1: the +1 enters through the preset carry flop.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_a      <= '0;
         r_b      <= '0;
         r_result <= '0;
         r_carry  <= 1'b0;
         r_cnt    <= '0;
         r_c_out  <= 1'b0;
         r_ovf    <= 1'b0;
      end else if (w_load) begin
         r_a     <= a;
         r_b     <= sub ? ~b : b;
         r_carry <= sub;
         r_cnt   <= '0;
         r_c_out <= 1'b0;
         r_ovf   <= 1'b0;
      end else if (w_step) begin
         r_a      <= r_a >> 1;
         r_b      <= r_b >> 1;
         r_carry  <= w_cout;
         r_cnt    <= r_cnt + 1'b1;
         r_result <= {w_sum, r_result[WIDTH-1:1]};
         if (w_last) begin
            // r_carry is the carry into the MSB on this last step
            r_c_out <= w_cout;
            r_ovf   <= r_carry ^ w_cout;
         end
      end
   end

   assign result = r_result;
   assign c_out  = r_c_out;
   assign ovf    = r_ovf;

`ifdef SERIAL_ADDSUB_ERR_EN
   logic r_err;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_err <= 1'b0;
      end else if ((r_state == S_RUN) && start) begin
         r_err <= 1'b1;
      end
   end

   assign err = r_err;
`endif

endmodule

// File: tb/tb_serial_addsub_nb.sv
// Scoreboard bench for serial_addsub_nb: driver pushes expected results,
// a negedge monitor pops and checks them whenever done is seen.
module tb_serial_addsub_nb;

   localparam int WIDTH = 16;

   typedef struct {
      logic [WIDTH-1:0] res;
      logic             c;
      logic             v;
      int               due;
   } exp_t;

   logic             clk;
   logic             rst;
   logic             start;
   logic             sub;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] result;
   logic             c_out;
   logic             ovf;
`ifdef SERIAL_ADDSUB_ERR_EN
   logic             err;
`endif

   int   checks = 0;
   int   errors = 0;
   int   cyc    = 0;
   exp_t exp_q[$];
   exp_t mon_e;

   serial_addsub_nb #(.WIDTH(WIDTH)) dut (
      .clk    (clk),
      .rst    (rst),
      .start  (start),
      .sub    (sub),
      .a      (a),
      .b      (b),
      .busy   (busy),
      .done   (done),
      .result (result),
      .c_out  (c_out),
      .ovf    (ovf)
`ifdef SERIAL_ADDSUB_ERR_EN
      ,
      .err    (err)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
      checks++;
      if (act !== expv) begin
         errors++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, expv, cyc);
      end
   endtask

   // Independent reference: plain integer arithmetic and sign-rule overflow.
   function automatic exp_t ref_op(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                                   input logic s, input int due);
      exp_t           e;
      logic [WIDTH:0] full;
      full  = s ? ({1'b0, x} - {1'b0, y}) : ({1'b0, x} + {1'b0, y});
      e.res = full[WIDTH-1:0];
      e.c   = s ? (x >= y) : full[WIDTH];
      e.v   = s ? ((x[WIDTH-1] != y[WIDTH-1]) && (e.res[WIDTH-1] != x[WIDTH-1]))
                : ((x[WIDTH-1] == y[WIDTH-1]) && (e.res[WIDTH-1] != x[WIDTH-1]));
      e.due = due;
      return e;
   endfunction

   // Drive one start pulse; k returns the cycle index right after the accepting edge.
   task automatic issue(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                        input logic s, output int k);
      a     = x;
      b     = y;
      sub   = s;
      start = 1'b1;
      @(posedge clk);
      #1;
      k     = cyc;
      start = 1'b0;
   endtask

   task automatic push(input logic [WIDTH-1:0] r, input logic c, input logic v, input int due);
      exp_t e;
      e.res = r;
      e.c   = c;
      e.v   = v;
      e.due = due;
      exp_q.push_back(e);
   endtask

   task automatic directed(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y, input logic s,
                           input logic [WIDTH-1:0] r, input logic c, input logic v);
      int k;
      issue(x, y, s, k);
      push(r, c, v, k + WIDTH);
      repeat (WIDTH + 1) @(posedge clk);
      #1;
   endtask

   always @(negedge clk) begin
      if (exp_q.size() > 0 && cyc > exp_q[0].due) begin
         mon_e = exp_q.pop_front();
         chk("done_timeout", 32'(cyc), 32'(mon_e.due));
      end
      if (done) begin
         if (exp_q.size() == 0) begin
            chk("unexpected_done", 32'(done), 32'd0);
         end else begin
            mon_e = exp_q.pop_front();
            chk("done_cycle", 32'(cyc), 32'(mon_e.due));
            chk("result", 32'(result), 32'(mon_e.res));
            chk("c_out", 32'(c_out), 32'(mon_e.c));
            chk("ovf", 32'(ovf), 32'(mon_e.v));
         end
      end
   end

   initial begin
      int k;
      int k2;
      logic [WIDTH-1:0] rx;
      logic [WIDTH-1:0] ry;
      logic             rs;
      exp_t             e;

      rst   = 1'b1;
      start = 1'b0;
      sub   = 1'b0;
      a     = '0;
      b     = '0;
      repeat (2) @(posedge clk);
      #1;
      chk("reset_busy", 32'(busy), 32'd0);
      chk("reset_done", 32'(done), 32'd0);
      chk("reset_result", 32'(result), 32'd0);
      chk("reset_c_out", 32'(c_out), 32'd0);
      chk("reset_ovf", 32'(ovf), 32'd0);
`ifdef SERIAL_ADDSUB_ERR_EN
      chk("reset_err", 32'(err), 32'd0);
`endif
      rst = 1'b0;
      @(posedge clk);
      #1;

      // 3+5 with busy window tracked cycle by cycle
      issue(16'h0003, 16'h0005, 1'b0, k);
      push(16'h0008, 1'b0, 1'b0, k + WIDTH);
      chk("busy_first", 32'(busy), 32'd1);
      repeat (WIDTH - 1) begin
         @(posedge clk);
         #1;
         chk("busy_run", 32'(busy), 32'd1);
      end
      @(posedge clk);
      #1;
      chk("busy_done_cycle", 32'(busy), 32'd0);
      @(posedge clk);
      #1;
      chk("done_low_idle", 32'(done), 32'd0);

      directed(16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0);
      directed(16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1);
      directed(16'h0005, 16'h0007, 1'b1, 16'hFFFE, 1'b0, 1'b0);
      directed(16'h8000, 16'h0001, 1'b1, 16'h7FFF, 1'b1, 1'b1);

      // start during RUN must be ignored
      issue(16'h1234, 16'h1111, 1'b0, k);
      push(16'h2345, 1'b0, 1'b0, k + WIDTH);
`ifdef SERIAL_ADDSUB_ERR_EN
      chk("err_before", 32'(err), 32'd0);
`endif
      repeat (3) @(posedge clk);
      #1;
      issue(16'hFFFF, 16'hFFFF, 1'b1, k2);
`ifdef SERIAL_ADDSUB_ERR_EN
      chk("err_set", 32'(err), 32'd1);
`endif
      chk("busy_after_ignored_start", 32'(busy), 32'd1);
      repeat (WIDTH) @(posedge clk);
      #1;
`ifdef SERIAL_ADDSUB_ERR_EN
      chk("err_sticky", 32'(err), 32'd1);
`endif

      // reset mid-run discards the operation
      issue(16'h4000, 16'h4000, 1'b0, k);
      push(16'h8000, 1'b0, 1'b1, k + WIDTH);
      repeat (7) @(posedge clk);
      #3;
      rst = 1'b1;
      exp_q.delete();
      #1;
      chk("midrst_busy", 32'(busy), 32'd0);
      chk("midrst_done", 32'(done), 32'd0);
      chk("midrst_result", 32'(result), 32'd0);
      chk("midrst_c_out", 32'(c_out), 32'd0);
      chk("midrst_ovf", 32'(ovf), 32'd0);
`ifdef SERIAL_ADDSUB_ERR_EN
      chk("midrst_err", 32'(err), 32'd0);
`endif
      @(posedge clk);
      #3;
      rst = 1'b0;
      repeat (WIDTH + 4) @(posedge clk);
      #1;
      directed(16'h0001, 16'h0001, 1'b0, 16'h0002, 1'b0, 1'b0);

      // back-to-back: second start issued in the done cycle
      issue(16'h00FF, 16'h0001, 1'b0, k);
      push(16'h0100, 1'b0, 1'b0, k + WIDTH);
      repeat (WIDTH) @(posedge clk);
      #1;
      chk("b2b_done_cycle", 32'(done), 32'd1);
      issue(16'h0010, 16'h0020, 1'b1, k2);
      push(16'hFFF0, 1'b0, 1'b0, k2 + WIDTH);
      chk("b2b_no_gap", 32'(k2 - k), 32'(WIDTH + 1));
      chk("b2b_busy", 32'(busy), 32'd1);
      repeat (WIDTH) @(posedge clk);
      #1;

      // random ops, chained back-to-back
      for (int i = 0; i < 500; i++) begin
         rx = WIDTH'($urandom);
         ry = WIDTH'($urandom);
         rs = 1'($urandom_range(0, 1));
         issue(rx, ry, rs, k);
         e = ref_op(rx, ry, rs, k + WIDTH);
         exp_q.push_back(e);
         repeat (WIDTH) @(posedge clk);
         #1;
      end

      for (int i = 0; i < 100 && exp_q.size() > 0; i++) begin
         @(posedge clk);
      end
      chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
      repeat (2) @(posedge clk);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/serial_addsub_nb.md
Name: serial_addsub_nb

Overview:
- Bit-serial two's-complement adder/subtractor built around a single 1-bit full-adder slice and a carry flop.
- Processes one bit per clock, LSB first.
- Accepts WIDTH-bit operands on a start pulse and reports result, carry-out and signed overflow with a one-cycle done pulse.
- Used where area matters more than latency; it is the sequential counterpart of the combinational ripple adders.

Parameters:
- WIDTH, 16, operand/result width in bits (>= 2).

Ports:
- clk  input  1  system clock, rising-edge active
- rst  input  1  asynchronous, active-high reset
- start  input  1  request new operation; sampled on rising edge
- sub  input  1  0 = a+b, 1 = a-b; sampled with start
- a  input  WIDTH  operand A; sampled with start
- b  input  WIDTH  operand B; sampled with start
- busy  output  1  high while an operation is in progress
- done  output  1  one-cycle pulse when result is valid
- result  output  WIDTH  sum/difference; held until next accepted start
- c_out  output  1  final carry (for sub: 1 = no borrow)
- ovf  output  1  signed overflow (carry into MSB XOR carry out of MSB)

Behaviour:
- One clock domain: clk. Reset is asynchronous and active-high on rst.
- Reset: state=IDLE; busy=0, done=0, result=0, c_out=0, ovf=0; internal operand shift registers, carry flop and bit counter cleared.
- States:
  - IDLE: waits for start.
  - RUN: processes one bit per edge.
  - DONE: one cycle, done=1.
- IDLE -> RUN on edge E0 where start=1:
  - Latch a.
  - Latch b, or ~b if sub=1.
  - Carry flop := sub.
  - Bit counter := 0.
  - Clear c_out and ovf.
- RUN, edges E1..E_WIDTH: each edge computes sum/carry of (A[0], B[0], carry) and shifts the sum bit into result MSB. Operands shift right, carry flop updates, counter increments.
  - On the edge processing bit WIDTH-1, capture carry-in to MSB for ovf.
  - Also on that edge: c_out := carry out, ovf := cin_msb ^ cout_msb, go to DONE.
- Latency: busy=1 from after E0 through the cycle ending at E_WIDTH. done=1 for exactly the cycle after E_WIDTH. result, c_out and ovf are valid and stable from that cycle on.
- DONE -> IDLE on the next edge, unless start=1, in which case a new operation is accepted (DONE -> RUN, same actions as IDLE -> RUN). Back-to-back throughput is one result per WIDTH+1 cycles.
- start while in RUN: ignored; operands not resampled, no effect on the in-flight result.
- result during RUN: partially shifted; only valid while done=1 or afterwards in IDLE.
- rst asserted mid-operation: immediate return to reset values; the in-flight operation is discarded and no done pulse is produced.
- Width rules: all arithmetic modulo 2^WIDTH.
  - Unsigned add: {c_out,result} == a+b.
  - Sub: result == (a-b) mod 2^WIDTH, c_out == (a >= b unsigned).

Optional Feature:
- Macro: SERIAL_ADDSUB_ERR_EN.
- Defined:
  - Adds output port err (1 bit), reset value 0.
  - err is sticky: set on any edge where start=1 while state=RUN; cleared only by rst.
  - The offending start is still ignored.
- Not defined: err port absent; start during RUN is silently ignored. All other behaviour is identical.

Test Plan (WIDTH=16):
- add a=0x0003, b=0x0005, sub=0 -> busy for 16 cycles; done exactly one cycle, after the 16th edge past start; result=0x0008, c_out=0, ovf=0.
- add a=0xFFFF, b=0x0001 -> result=0x0000, c_out=1, ovf=0; add a=0x7FFF, b=0x0001 -> result=0x8000, c_out=0, ovf=1.
- sub a=0x0005, b=0x0007 -> result=0xFFFE, c_out=0, ovf=0; sub a=0x8000, b=0x0001 -> result=0x7FFF, c_out=1, ovf=1.
- Start 0x1234+0x1111, then pulse start with a=0xFFFF, b=0xFFFF at cycle 5 -> result=0x2345, done still on original cycle. With SERIAL_ADDSUB_ERR_EN, err=1 from that edge until rst.
- rst pulsed at cycle 8 of a run -> all outputs 0 immediately; no done pulse; next start 0x0001+0x0001 -> result=0x0002.
- Start held high during done cycle with new operands -> accepted with no IDLE gap. Then 500 random {a,b,sub} ops checked at each done against a+b / a-b reference values for result, c_out and ovf.
